// File: rtl/pwm_capture.sv
// Measures high time and period of an asynchronous PWM input in clk cycles,
// reporting each completed period with a one-cycle valid strobe plus stuck-line detection.
module pwm_capture #(
  parameter int CNT_W = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_out,
  output logic [CNT_W-1:0] period_out,
  output logic             valid,
  output logic             stuck,
  output logic             stuck_level
);

  typedef enum logic {
    IDLE,
    MEAS
  } state_t;

  // All-ones: a period reaching this count without a rising edge is a stuck line.
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]       sync_reg;
  logic             s_d_reg;
  logic             s;
  logic             rise;

  state_t           state_reg;
  logic [CNT_W-1:0] per_cnt_reg;
  logic [CNT_W-1:0] high_cnt_reg;
  logic [CNT_W-1:0] high_out_reg;
  logic [CNT_W-1:0] period_out_reg;
  logic             valid_reg;
  logic             stuck_reg;
  logic             stuck_level_reg;

  assign s    = sync_reg[1];
  assign rise = s & ~s_d_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= 2'b00;
      s_d_reg  <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[0], pwm_in};
      s_d_reg  <= s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      per_cnt_reg     <= '0;
      high_cnt_reg    <= '0;
      high_out_reg    <= '0;
      period_out_reg  <= '0;
      valid_reg       <= 1'b0;
      stuck_reg       <= 1'b0;
      stuck_level_reg <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          // The first edge only establishes the reference point for timing.
          if (rise) begin
            state_reg    <= MEAS;
            per_cnt_reg  <= CNT_ONE;
            high_cnt_reg <= CNT_ONE;
            stuck_reg    <= 1'b0;
          end
        end
        MEAS: begin
          if (rise) begin
            high_out_reg   <= high_cnt_reg;
            period_out_reg <= per_cnt_reg;
            valid_reg      <= 1'b1;
            per_cnt_reg    <= CNT_ONE;
            high_cnt_reg   <= CNT_ONE;
          end else if (per_cnt_reg == CNT_MAX) begin
            state_reg       <= IDLE;
            stuck_reg       <= 1'b1;
            stuck_level_reg <= s;
            per_cnt_reg     <= '0;
            high_cnt_reg    <= '0;
          end else begin
            per_cnt_reg <= per_cnt_reg + CNT_ONE;
            if (s) begin
              high_cnt_reg <= high_cnt_reg + CNT_ONE;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign high_out    = high_out_reg;
  assign period_out  = period_out_reg;
  assign valid       = valid_reg;
  assign stuck       = stuck_reg;
  assign stuck_level = stuck_level_reg;

endmodule
